ram_access_arbiter: RTL and testbench

//  Shares the single DRAM array among four requesters: CPU, video DMA, sound DMA and refresh.

---
 rtl/ram_access_arbiter.sv | 86 ++++++++
 tb/tb_ram_access_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: shares one DRAM array among CPU, video DMA, sound DMA and CAS-before-RAS refresh,
// one registered RAS/CAS cycle at a time, with a CPU anti-starvation guard.
module ram_access_arbiter #(
  parameter int RAS_CYC     = 2,
  parameter int CAS_CYC     = 2,
  parameter int PRE_CYC     = 2,
  parameter int REF_CYC     = 3,
  parameter int CPU_MAXWAIT = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RefReq,
  input  logic       RefUrg,
  output logic       RefAck,
  input  logic       CPUReq,
  output logic       CPUAck,
  input  logic       VidReq,
  output logic       VidAck,
  input  logic       SndReq,
  output logic       SndAck,
  output logic [2:0] Gnt,
  output logic       RASn,
  output logic       CASn
);
  localparam int PMAXA = RAS_CYC > CAS_CYC ? RAS_CYC : CAS_CYC;
  localparam int PMAXB = PRE_CYC > REF_CYC ? PRE_CYC : REF_CYC;
  localparam int PMAX  = PMAXA > PMAXB ? PMAXA : PMAXB;
  localparam int CW    = $clog2(PMAX + 1);
  localparam int WW    = $clog2(CPU_MAXWAIT + 1);
  typedef enum logic [2:0] {IDLE, RAS, CAS, CBR, REF, PRE} state_t;
  state_t state, nState;
  logic [CW-1:0] phase, nPhase;
  logic [2:0] nGnt;
  logic [WW-1:0] waitCnt;
  logic refDone, refP, urgP, starved, phaseEnd, accAck;
  int len;
  always_comb begin
    refP = RefReq & ~refDone;
    urgP = RefUrg & ~refDone;
    starved = CPUReq && waitCnt == WW'(CPU_MAXWAIT);
    len = state == RAS ? RAS_CYC : state == CAS ? CAS_CYC : state == REF ? REF_CYC : state == PRE ? PRE_CYC : 1;
    phaseEnd = phase == CW'(len - 1);
    nState = state;
    nPhase = phase + 1'b1;
    nGnt = Gnt;
    if (state == IDLE) begin
      nPhase = '0;
      nGnt = urgP ? 3'd4 : VidReq ? 3'd2 : starved ? 3'd1 : SndReq ? 3'd3 : CPUReq ? 3'd1 : refP ? 3'd4 : 3'd0;
      nState = nGnt == 3'd0 ? IDLE : nGnt == 3'd4 ? CBR : RAS;
    end else if (phaseEnd) begin
      nPhase = '0;
      nState = state == RAS ? CAS : state == CBR ? REF : state == PRE ? IDLE : PRE;
      if (state == PRE) nGnt = 3'd0;
    end
    accAck = nState == CAS && nPhase == CW'(CAS_CYC - 1);
  end
  // Strobes and acks are decoded from the next state so every output is a flop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      phase   <= '0;
      Gnt     <= 3'd0;
      RASn    <= 1'b1;
      CASn    <= 1'b1;
      CPUAck  <= 1'b0;
      VidAck  <= 1'b0;
      SndAck  <= 1'b0;
      RefAck  <= 1'b0;
      refDone <= 1'b0;
      waitCnt <= '0;
    end else begin
      state   <= nState;
      phase   <= nPhase;
      Gnt     <= nGnt;
      RASn    <= !(nState inside {RAS, CAS, REF});
      CASn    <= !(nState inside {CAS, CBR, REF});
      CPUAck  <= accAck && nGnt == 3'd1;
      VidAck  <= accAck && nGnt == 3'd2;
      SndAck  <= accAck && nGnt == 3'd3;
      RefAck  <= nState == REF && nPhase == CW'(REF_CYC - 1);
      refDone <= RefReq & (refDone | RefAck);
      waitCnt <= (!CPUReq || CPUAck) ? '0 :
                 (Gnt != 3'd1 && waitCnt != WW'(CPU_MAXWAIT)) ? waitCnt + 1'b1 : waitCnt;
    end
  end
endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: directed scenarios plus randomized traffic checked cycle by cycle against
// a model that expands each grant into its expected output waveform.
module tb_ram_access_arbiter;
  localparam int RAS_CYC = 2, CAS_CYC = 2, PRE_CYC = 2, REF_CYC = 3, CPU_MAXWAIT = 8;
  logic CLK = 1'b0, RST = 1'b1;
  logic RefReq = 1'b0, RefUrg = 1'b0, CPUReq = 1'b0, VidReq = 1'b0, SndReq = 1'b0;
  logic RefAck, CPUAck, VidAck, SndAck, RASn, CASn;
  logic [2:0] Gnt;
  ram_access_arbiter dut (
    .CLK(CLK), .RST(RST), .RefReq(RefReq), .RefUrg(RefUrg), .RefAck(RefAck),
    .CPUReq(CPUReq), .CPUAck(CPUAck), .VidReq(VidReq), .VidAck(VidAck),
    .SndReq(SndReq), .SndAck(SndAck), .Gnt(Gnt), .RASn(RASn), .CASn(CASn)
  );
  always #5 CLK = ~CLK;
  typedef struct packed {logic r; logic c; logic [2:0] g; logic [3:0] a;} frame_t;
  localparam frame_t IDLEF = frame_t'(9'b1_1_000_0000);
  frame_t plan[$];
  frame_t cur;
  bit curIdle, mRefDone;
  int mWait, checks, errors, cyc, cpuRe, vidRe, sndRe;
  int order[$];
  int gntCyc[$];
  logic [2:0] prevGnt;
  function automatic frame_t mk(logic r, logic c, logic [2:0] g, logic [3:0] a);
    return {r, c, g, a};
  endfunction
  function automatic logic [11:0] first4();
    logic [11:0] v = '0;
    for (int i = 0; i < 4; i++) if (i < order.size()) v[11-3*i -: 3] = order[i][2:0];
    return v;
  endfunction
  task automatic model_reset();
    plan.delete();
    cur = IDLEF;
    curIdle = 1;
    mRefDone = 0;
    mWait = 0;
    prevGnt = 3'd0;
  endtask
  task automatic push_acc(logic [2:0] g, logic [3:0] ackMask);
    for (int i = 0; i < RAS_CYC; i++) plan.push_back(mk(1'b0, 1'b1, g, 4'd0));
    for (int i = 0; i < CAS_CYC; i++) plan.push_back(mk(1'b0, 1'b0, g, i == CAS_CYC - 1 ? ackMask : 4'd0));
    for (int i = 0; i < PRE_CYC; i++) plan.push_back(mk(1'b1, 1'b1, g, 4'd0));
  endtask
  task automatic push_ref();
    plan.push_back(mk(1'b1, 1'b0, 3'd4, 4'd0));
    for (int i = 0; i < REF_CYC; i++) plan.push_back(mk(1'b0, 1'b0, 3'd4, i == REF_CYC - 1 ? 4'b1000 : 4'd0));
    for (int i = 0; i < PRE_CYC; i++) plan.push_back(mk(1'b1, 1'b1, 3'd4, 4'd0));
  endtask
  task automatic tick();
    bit up, rp;
    logic [8:0] dv;
    @(posedge CLK);
    cyc++;
    if (curIdle) begin
      up = RefUrg && !mRefDone;
      rp = RefReq && !mRefDone;
      if (up) push_ref();
      else if (VidReq) push_acc(3'd2, 4'b0010);
      else if (CPUReq && mWait == CPU_MAXWAIT) push_acc(3'd1, 4'b0001);
      else if (SndReq) push_acc(3'd3, 4'b0100);
      else if (CPUReq) push_acc(3'd1, 4'b0001);
      else if (rp) push_ref();
    end
    mWait = (!CPUReq || cur.a[0]) ? 0 : (cur.g != 3'd1 && mWait < CPU_MAXWAIT) ? mWait + 1 : mWait;
    mRefDone = RefReq && (mRefDone || cur.a[3]);
    if (plan.size() > 0) begin
      cur = plan.pop_front();
      curIdle = 0;
    end else begin
      cur = IDLEF;
      curIdle = 1;
    end
    #1;
    dv = {RASn, CASn, Gnt, RefAck, SndAck, VidAck, CPUAck};
    checks++;
    if (dv !== cur) begin
      errors++;
      $display("FAIL frame t=%0t got %b want %b (RASn CASn Gnt Ref/Snd/Vid/CPU ack)", $time, dv, 9'(cur));
    end
    if (Gnt != 3'd0 && prevGnt == 3'd0) begin
      order.push_back(int'(Gnt));
      gntCyc.push_back(cyc);
    end
    prevGnt = Gnt;
  endtask
  task automatic run(int n);
    repeat (n) begin
      tick();
      if (CPUAck) CPUReq = 0; else if (!CPUReq && cpuRe > 0) begin CPUReq = 1; cpuRe--; end
      if (VidAck) VidReq = 0; else if (!VidReq && vidRe > 0) begin VidReq = 1; vidRe--; end
      if (SndAck) SndReq = 0; else if (!SndReq && sndRe > 0) begin SndReq = 1; sndRe--; end
      if (RefAck) RefUrg = 0;
    end
  endtask
  task automatic test_reset();
    RST = 1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({RASn, CASn, Gnt, RefAck, SndAck, VidAck, CPUAck} !== 9'b1_1_000_0000) begin
      errors++;
      $display("FAIL reset_state got %b want 110000000", {RASn, CASn, Gnt, RefAck, SndAck, VidAck, CPUAck});
    end
    @(negedge CLK) RST = 0;
    model_reset();
    CPUReq = 1;
    run(3);
    #3 RST = 1;
    #1;
    checks++;
    if ({RASn, CASn, Gnt, CPUAck} !== 6'b11_000_0) begin
      errors++;
      $display("FAIL reset_mid_cas got %b want 110000", {RASn, CASn, Gnt, CPUAck});
    end
    repeat (3) begin
      @(posedge CLK);
      #1;
      checks++;
      if ({RASn, CPUAck} !== 2'b10) begin
        errors++;
        $display("FAIL reset_hold got RASn/CPUAck %b want 10", {RASn, CPUAck});
      end
    end
    CPUReq = 0;
    @(negedge CLK) RST = 0;
    model_reset();
    run(2);
  endtask
  task automatic test_cpu_single();
    logic [5:0] exp;
    CPUReq = 1;
    for (int j = 1; j <= 8; j++) begin
      run(1);
      exp = {(j <= 4) ? 1'b0 : 1'b1, (j == 3 || j == 4) ? 1'b0 : 1'b1, (j <= 6) ? 3'd1 : 3'd0, (j == 4) ? 1'b1 : 1'b0};
      checks++;
      if ({RASn, CASn, Gnt, CPUAck} !== exp) begin
        errors++;
        $display("FAIL cpu_timing k+%0d got %b want %b", j, {RASn, CASn, Gnt, CPUAck}, exp);
      end
    end
  endtask
  task automatic test_back_to_back();
    gntCyc.delete();
    CPUReq = 1;
    cpuRe = 1;
    run(20);
    checks++;
    if (gntCyc.size() != 2 || gntCyc[1] - gntCyc[0] != 7) begin
      errors++;
      $display("FAIL back_to_back got %0d grants spacing %0d want 2 grants spacing 7",
               gntCyc.size(), gntCyc.size() == 2 ? gntCyc[1] - gntCyc[0] : -1);
    end
    run(4);
  endtask
  task automatic test_priority();
    order.delete();
    RefReq = 1;
    RefUrg = 1;
    VidReq = 1;
    CPUReq = 1;
    run(30);
    checks++;
    if (first4() !== {3'd4, 3'd2, 3'd1, 3'd0}) begin
      errors++;
      $display("FAIL priority_order got %h want %h", first4(), {3'd4, 3'd2, 3'd1, 3'd0});
    end
    RefReq = 0;
    run(4);
  endtask
  task automatic test_refresh_once();
    int n = 0;
    RefReq = 1;
    repeat (40) begin run(1); n += int'(RefAck); end
    checks++;
    if (n != 1) begin errors++; $display("FAIL refresh_once got %0d RefAck want 1", n); end
    RefReq = 0;
    run(1);
    RefReq = 1;
    n = 0;
    repeat (15) begin run(1); n += int'(RefAck); end
    checks++;
    if (n != 1) begin errors++; $display("FAIL refresh_again got %0d RefAck want 1", n); end
    RefReq = 0;
    run(8);
  endtask
  task automatic test_starvation();
    order.delete();
    VidReq = 1;
    SndReq = 1;
    CPUReq = 1;
    vidRe = 1;
    sndRe = 1;
    run(40);
    checks++;
    if (first4() !== {3'd2, 3'd2, 3'd1, 3'd3}) begin
      errors++;
      $display("FAIL starvation_order got %h want %h", first4(), {3'd2, 3'd2, 3'd1, 3'd3});
    end
    run(10);
    order.delete();
    SndReq = 1;
    CPUReq = 1;
    run(20);
    checks++;
    if (first4() !== {3'd3, 3'd1, 3'd0, 3'd0}) begin
      errors++;
      $display("FAIL fresh_cpu_order got %h want %h", first4(), {3'd3, 3'd1, 3'd0, 3'd0});
    end
    run(4);
  endtask
  task automatic test_snd_drop();
    int acks, rasLow;
    SndReq = 1;
    run(1);
    checks++;
    if (Gnt !== 3'd3) begin errors++; $display("FAIL snd_grant got %0d want 3", Gnt); end
    SndReq = 0;
    acks = 0;
    rasLow = int'(!RASn);
    repeat (8) begin run(1); acks += int'(SndAck); rasLow += int'(!RASn); end
    checks++;
    if (acks != 1 || rasLow != 4) begin
      errors++;
      $display("FAIL snd_drop got acks %0d rasLow %0d want acks 1 rasLow 4", acks, rasLow);
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      run(1);
      if (!CPUReq && !CPUAck && $urandom_range(0, 5) == 0) CPUReq = 1;
      if (!VidReq && !VidAck && $urandom_range(0, 9) == 0) VidReq = 1;
      if (!SndReq && !SndAck && $urandom_range(0, 6) == 0) SndReq = 1;
      if ($urandom_range(0, 39) == 0) RefReq = ~RefReq;
      if (RefReq && !RefAck && $urandom_range(0, 59) == 0) RefUrg = 1;
    end
    CPUReq = 0;
    VidReq = 0;
    SndReq = 0;
    RefReq = 0;
    RefUrg = 0;
    run(12);
  endtask
  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    cpuRe = 0;
    vidRe = 0;
    sndRe = 0;
    model_reset();
    test_reset();
    test_cpu_single();
    test_back_to_back();
    test_priority();
    test_refresh_once();
    test_starvation();
    test_snd_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
